// File: rtl/mem_state_dumper.sv
// End-of-run state dump engine: walks enabled storage channels word by word and streams
// {channel, byte address, data} records over valid/ready. Optional trailers: DUMP_CHECKSUM_EN.
module mem_state_dumper #(
  parameter int unsigned            NUM_CH  = 4,
  parameter int unsigned            DEPTH   = 64,
  parameter int unsigned            IDX_W   = 6,
  parameter int unsigned            DATA_W  = 32,
  parameter logic [32*NUM_CH-1:0]   CH_BASE = {32'h1001_0000, 32'h0, 32'h1000_0000, 32'h0}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              rd_en,
  output logic [2:0]        rd_ch,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_ch,
  output logic [31:0]       out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StEmit, StDone} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [2:0]          ch_q, ch_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [2:0]          out_ch_q, out_ch_d;
  logic [31:0]         out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic [2:0]          first_ch, nxt_ch;
  logic                nxt_found;
  logic [31:0]         base, rd_addr;
  logic                last_word, xfer, start_ok, ch_end, trl_start;

  // Lowest enabled channel in the incoming mask, and next enabled channel above ch_q.
  always_comb begin
    first_ch  = '0;
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 3'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = 3'(i);
      end
    end
  end

  always_comb begin
    base = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (int'(ch_q) == i) base = CH_BASE[32*i +: 32];
    end
  end

  assign rd_addr   = base + (32'(idx_q) << 2);
  assign last_word = (idx_q == IDX_W'(DEPTH - 1));
  assign xfer      = (state_q == StEmit) && out_ready && !abort;
  assign start_ok  = (state_q == StIdle) && start && !abort;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              trl_q, trl_d;

  // A channel ends on its trailer; the last data word instead launches the trailer.
  assign ch_end    = trl_q;
  assign trl_start = !trl_q && last_word;

  always_comb begin
    acc_d = acc_q;
    trl_d = trl_q;
    if (start_ok) begin
      acc_d = '0;
      trl_d = 1'b0;
    end
    if ((state_q == StCap) && !abort) acc_d = acc_q ^ rd_data;
    if (xfer) begin
      trl_d = trl_start;
      if (trl_q) acc_d = '0;
    end
    if (abort) trl_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      trl_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      trl_q <= trl_d;
    end
  end
`else
  assign ch_end    = last_word;
  assign trl_start = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_ok) state_d = (ch_mask != '0) ? StRd : StDone;
      StRd:   state_d = abort ? StDone : StCap;
      StCap:  state_d = abort ? StDone : StEmit;
      StEmit: begin
        if (abort) begin
          state_d = StDone;
        end else if (out_ready) begin
          if (ch_end)         state_d = nxt_found ? StRd : StDone;
          else if (trl_start) state_d = StEmit;
          else                state_d = StRd;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rd_en     = (state_q == StRd);
    rd_ch     = rd_en ? ch_q : 3'd0;
    rd_idx    = rd_en ? idx_q : '0;
    out_valid = (state_q == StEmit);
    busy      = (state_q == StRd) || (state_q == StCap) || (state_q == StEmit);
    done      = (state_q == StDone);
    out_ch    = out_ch_q;
    out_addr  = out_addr_q;
    out_data  = out_data_q;
    out_last  = out_last_q && out_valid;
  end

  // Walk counters and output record registers.
  always_comb begin
    mask_d     = mask_q;
    ch_d       = ch_q;
    idx_d      = idx_q;
    out_ch_d   = out_ch_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (start_ok) begin
      mask_d = ch_mask;
      ch_d   = first_ch;
      idx_d  = '0;
    end
    if ((state_q == StCap) && !abort) begin
      out_ch_d   = ch_q;
      out_addr_d = rd_addr;
      out_data_d = rd_data;
`ifdef DUMP_CHECKSUM_EN
      out_last_d = 1'b0;
`else
      out_last_d = last_word && !nxt_found;
`endif
    end
    if (xfer) begin
      if (trl_start) begin
`ifdef DUMP_CHECKSUM_EN
        out_addr_d = 32'hFFFF_FFFC;
        out_data_d = acc_q;
        out_last_d = !nxt_found;
`endif
      end else if (ch_end) begin
        idx_d = '0;
        if (nxt_found) ch_d = nxt_ch;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q     <= '0;
      ch_q       <= '0;
      idx_q      <= '0;
      out_ch_q   <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      ch_q       <= ch_d;
      idx_q      <= idx_d;
      out_ch_q   <= out_ch_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: tb/tb_mem_state_dumper.sv
// Self-checking bench for mem_state_dumper: random storage contents and random backpressure,
// checked against a record list built directly from the channel walk rules.
module tb_mem_state_dumper;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic              rd_en;
  logic [2:0]        rd_ch;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2:0]        out_ch;
  logic [31:0]       out_addr;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [NUM_CH][DEPTH];

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } rec_t;

  rec_t exp_q[$];

  mem_state_dumper dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ch_mask(ch_mask),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Storage mux: data valid exactly one cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    if (rd_en && rd_ch < 3'(NUM_CH)) rd_data <= mem[rd_ch[1:0]][rd_idx];
    else                             rd_data <= $urandom;
  end

  function automatic logic [31:0] base_of(input int ch);
    case (ch)
      1:       return 32'h1000_0000;
      3:       return 32'h1001_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic build_expected(input logic [NUM_CH-1:0] mask);
    rec_t r;
    logic [31:0] x;
    exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask[c]) begin
        x = '0;
        for (int i = 0; i < DEPTH; i++) begin
          r = '{ch: 3'(c), addr: base_of(c) + 32'(i) * 4, data: mem[c][i], last: 1'b0};
          exp_q.push_back(r);
          x = x ^ mem[c][i];
        end
`ifdef DUMP_CHECKSUM_EN
        r = '{ch: 3'(c), addr: 32'hFFFF_FFFC, data: x, last: 1'b0};
        exp_q.push_back(r);
`endif
      end
    end
    if (exp_q.size() > 0) begin
      r = exp_q.pop_back();
      r.last = 1'b1;
      exp_q.push_back(r);
    end
  endtask

  task automatic run_dump(input logic [NUM_CH-1:0] mask, input bit rand_ready,
                          input bit poke_start);
    rec_t cur, prev, e;
    bit   prev_stall = 0;
    bit   prev_busy = 0;
    int   first_k = -1, last_x = -1, done_k = -1, nrec = 0;
    build_expected(mask);
    @(negedge clk);
    ch_mask = mask; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; ch_mask = NUM_CH'($urandom);
    n_checks++;
    if (busy !== (mask != 0)) begin
      n_fail++; $display("FAIL busy_rise: got %b expected %b", busy, mask != 0);
    end
    for (int k = 1; k < 5000; k++) begin
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      start     = poke_start && (k == 40);
      cur = '{ch: out_ch, addr: out_addr, data: out_data, last: out_last};
      if (prev_stall) begin
        n_checks++;
        if (!out_valid || cur !== prev) begin
          n_fail++; $display("FAIL stall_stable k=%0d: got %h expected %h", k, cur, prev);
        end
      end
      if (rd_en) begin
        n_checks++;
        if (rd_ch >= 3'(NUM_CH)) begin n_fail++; $display("FAIL rd_ch: got %0d", rd_ch); end
      end
      if (out_valid && first_k < 0) begin
        first_k = k;
        n_checks++;
        if (k != 3) begin n_fail++; $display("FAIL latency: got %0d expected 3", k); end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_record: got %h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL record %0d: got ch=%0d addr=%h data=%h last=%b expected ch=%0d addr=%h data=%h last=%b",
                     nrec, cur.ch, cur.addr, cur.data, cur.last, e.ch, e.addr, e.data, e.last);
          end
        end
        if (!rand_ready && last_x >= 0) begin
          n_checks++;
          if (k - last_x != 3) begin
            n_fail++; $display("FAIL throughput: got %0d cycles expected 3", k - last_x);
          end
        end
        last_x = k;
        nrec++;
      end
      if (mask == 0) begin
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
          n_fail++; $display("FAIL zero_mask_idle: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
      end
      if (done_k >= 0) begin
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
        break;
      end
      if (done === 1'b1) begin
        done_k = k;
        n_checks++;
        if (busy !== 1'b0 || prev_busy !== (mask != 0) || exp_q.size() != 0) begin
          n_fail++;
          $display("FAIL done_end: got busy=%b prev_busy=%b left=%0d expected 0 %b 0",
                   busy, prev_busy, exp_q.size(), mask != 0);
        end
        if (mask == 0) begin
          n_checks++;
          if (k != 1) begin n_fail++; $display("FAIL zero_done: got k=%0d expected 1", k); end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev       = cur;
      prev_busy  = busy;
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (done_k < 0) begin n_fail++; $display("FAIL timeout: got no done expected done"); end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rd_en, rd_ch, rd_idx, out_valid, out_ch, out_addr, out_data, out_last, busy, done} !== '0)
    begin
      n_fail++; $display("FAIL reset_outputs: got nonzero expected all 0");
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_dump;
    run_dump(4'b1111, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    run_dump(4'b1111, 1'b1, 1'b1);
    run_dump(NUM_CH'($urandom_range(1, 15)), 1'b1, 1'b0);
  endtask

  task automatic test_sparse;
    run_dump(4'b1010, 1'b0, 1'b0);
  endtask

  task automatic test_zero_mask;
    run_dump(4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; ch_mask = 4'b1111;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rd_en !== 1'b0) begin
        n_fail++; $display("FAIL start_abort_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_abort;
    int cnt = 0;
    @(negedge clk);
    ch_mask = 4'b1111; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 500 && cnt < 10; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: got valid=%b expected 1", out_valid);
    end
    abort = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_response: got valid=%b done=%b busy=%b rd_en=%b expected 0 1 0 0",
               out_valid, done, busy, rd_en);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got done=%b valid=%b expected 0 0", done, out_valid);
    end
    run_dump(4'b1111, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ch_mask = 4'b1111; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({rd_en, rd_ch, rd_idx, out_valid, out_ch, out_addr, out_data, out_last, busy, done} !== '0)
    begin
      n_fail++; $display("FAIL reset_mid: got valid=%b busy=%b addr=%h expected all 0",
                         out_valid, busy, out_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    run_dump(4'b1111, 1'b1, 1'b0);
  endtask

`ifdef DUMP_CHECKSUM_EN
  task automatic test_checksum;
    for (int i = 0; i < DEPTH; i++) mem[0][i] = 32'h1;
    run_dump(4'b0001, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) mem[0][i] = 32'(i);
    run_dump(4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) mem[0][i] = (i == 0) ? 32'hA5 : 32'h0;
    run_dump(4'b0101, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < DEPTH; i++) mem[c][i] = $urandom;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_sparse();
    test_zero_mask();
    test_abort();
    test_reset_mid();
`ifdef DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
